// File: rtl/ysyx_23060236_csr_pkg.sv
// Shared CSR addresses, op encodings, mcause codes and mstatus bit positions
// for the NPC machine-mode CSR/trap unit.
package ysyx_23060236_csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_WRITE = 2'b01,
      OP_SET   = 2'b10,
      OP_CLEAR = 2'b11
   } csr_op_e;

   localparam logic [3:0] CAUSE_MTI    = 4'd7;
   localparam logic [3:0] CAUSE_ECALL  = 4'd11;
   localparam logic [3:0] CAUSE_EBREAK = 4'd3;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MSTATUS_MPP  = 11;
   localparam int MIX_MT       = 7;

endpackage

// File: rtl/ysyx_23060236_csr_trap_unit_counter.sv
// 64-bit event counter with increment enable and independent half writes;
// a half write wins over the increment and leaves the other half untouched.
module ysyx_23060236_csr_counter (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_inc,
   input  logic        i_wr_lo,
   input  logic        i_wr_hi,
   input  logic [63:0] i_wdata,
   output logic [63:0] o_cnt
);

   logic [63:0] r_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_wr_lo | i_wr_hi) begin
         if (i_wr_lo) r_cnt[31:0]  <= i_wdata[31:0];
         if (i_wr_hi) r_cnt[63:32] <= i_wdata[63:32];
      end else if (i_inc) begin
         r_cnt <= r_cnt + 64'd1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/ysyx_23060236_csr_trap_unit.sv
// Machine-mode CSR file and trap controller (Zicsr, ecall/ebreak/mret, MTI).
// Define CSR_COUNTERS_EN to implement mcycle/minstret.
module ysyx_23060236_csr_trap_unit
   import ysyx_23060236_csr_pkg::*;
#(
   parameter int          XLEN      = 32,
   parameter logic [31:0] MVENDORID = 32'h79737978,
   parameter logic [31:0] MARCHID   = 32'h015fdf0c,
   parameter bit          MTVEC_VEC = 1'b1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            valid,
   input  logic [11:0]     csr_addr,
   input  logic [1:0]      csr_op,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            inst_ecall,
   input  logic            inst_ebreak,
   input  logic            inst_mret,
   input  logic [XLEN-1:0] epc,
   input  logic            timer_irq,
   output logic [XLEN-1:0] jump,
   output logic            jump_en,
   output logic            trap_taken
);

   localparam logic [XLEN-1:0] EPC_MASK =
      {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [XLEN-1:0] TVEC_MASK =
      {{(XLEN-2){1'b1}}, 1'b0, MTVEC_VEC};

   logic            r_mie;
   logic            r_mpie;
   logic            r_mtie;
   logic            r_mtip;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;

   logic [XLEN-1:0] w_mstatus;
   logic [XLEN-1:0] w_mtvec;
   logic [XLEN-1:0] w_mepc;
   logic [XLEN-1:0] w_base;
   logic [XLEN-1:0] w_old;
   logic [XLEN-1:0] w_new;
   logic [XLEN-1:0] w_cause;
   logic [XLEN-1:0] w_trap_pc;
   logic [63:0]     w_mcycle;
   logic [63:0]     w_minstret;
   logic            w_impl;
   logic            w_ro;
   logic            w_wr;
   logic            w_irq;
   logic            w_sync;
   logic            w_trap;
   logic            w_mret;
   logic            w_csr_we;

   always_comb begin
      w_mstatus = '0;
      w_mstatus[MSTATUS_MPP+1:MSTATUS_MPP] = 2'b11;
      w_mstatus[MSTATUS_MPIE] = r_mpie;
      w_mstatus[MSTATUS_MIE]  = r_mie;
   end

   assign w_mtvec = r_mtvec & TVEC_MASK;
   assign w_mepc  = r_mepc & EPC_MASK;
   assign w_base  = {w_mtvec[XLEN-1:2], 2'b00};

   always_comb begin
      w_old  = '0;
      w_impl = 1'b1;
      w_ro   = 1'b0;
      case (csr_addr)
         CSR_MSTATUS: w_old = w_mstatus;
         CSR_MIE:     w_old[MIX_MT] = r_mtie;
         CSR_MTVEC:   w_old = w_mtvec;
         CSR_MEPC:    w_old = w_mepc;
         CSR_MCAUSE:  w_old = r_mcause;
         CSR_MIP: begin
            w_old[MIX_MT] = r_mtip;
            w_ro = 1'b1;
         end
         CSR_MVENDORID: begin
            w_old[31:0] = MVENDORID;
            w_ro = 1'b1;
         end
         CSR_MARCHID: begin
            w_old[31:0] = MARCHID;
            w_ro = 1'b1;
         end
         CSR_MCYCLE:   w_old = w_mcycle[XLEN-1:0];
         CSR_MINSTRET: w_old = w_minstret[XLEN-1:0];
         CSR_MCYCLEH: begin
            if (XLEN == 32) w_old[31:0] = w_mcycle[63:32];
            else            w_impl = 1'b0;
         end
         CSR_MINSTRETH: begin
            if (XLEN == 32) w_old[31:0] = w_minstret[63:32];
            else            w_impl = 1'b0;
         end
         default: w_impl = 1'b0;
      endcase
   end

   always_comb begin
      w_new = w_old;
      w_wr  = 1'b0;
      unique case (csr_op_e'(csr_op))
         OP_WRITE: begin
            w_new = csr_wdata;
            w_wr  = 1'b1;
         end
         OP_SET: begin
            w_new = w_old | csr_wdata;
            w_wr  = |csr_wdata;
         end
         OP_CLEAR: begin
            w_new = w_old & ~csr_wdata;
            w_wr  = |csr_wdata;
         end
         default: ;
      endcase
   end

   assign csr_rdata   = w_old;
   assign csr_illegal = (csr_op != OP_NONE) & (~w_impl | (w_ro & w_wr));

   assign w_irq  = r_mtip & r_mtie & r_mie;
   assign w_sync = inst_ecall | inst_ebreak;
   assign w_trap = valid & ~reset & (w_irq | w_sync);
   assign w_mret = valid & ~reset & ~w_irq & ~w_sync & inst_mret;
   // Any redirecting instruction owns the cycle; its CSR op is dropped.
   assign w_csr_we = valid & ~(w_irq | w_sync | inst_mret)
                   & w_wr & ~csr_illegal;

   always_comb begin
      w_cause = '0;
      priority if (w_irq) begin
         w_cause[XLEN-1] = 1'b1;
         w_cause[3:0]    = CAUSE_MTI;
      end else if (inst_ecall) begin
         w_cause[3:0] = CAUSE_ECALL;
      end else begin
         w_cause[3:0] = CAUSE_EBREAK;
      end
   end

   assign w_trap_pc = (w_irq & w_mtvec[0])
                    ? w_base + XLEN'({CAUSE_MTI, 2'b00})
                    : w_base;

   assign jump       = w_mret ? w_mepc : w_trap_pc;
   assign jump_en    = w_trap | w_mret;
   assign trap_taken = w_trap;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_mie    <= 1'b0;
         r_mpie   <= 1'b0;
         r_mtie   <= 1'b0;
         r_mtip   <= 1'b0;
         r_mtvec  <= '0;
         r_mepc   <= '0;
         r_mcause <= '0;
      end else begin
         r_mtip <= timer_irq;
         if (w_trap) begin
            r_mepc   <= epc;
            r_mcause <= w_cause;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
         end else if (w_mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
         end else if (w_csr_we) begin
            case (csr_addr)
               CSR_MSTATUS: begin
                  r_mie  <= w_new[MSTATUS_MIE];
                  r_mpie <= w_new[MSTATUS_MPIE];
               end
               CSR_MIE:    r_mtie   <= w_new[MIX_MT];
               CSR_MTVEC:  r_mtvec  <= w_new;
               CSR_MEPC:   r_mepc   <= w_new;
               CSR_MCAUSE: r_mcause <= w_new;
               default: ;
            endcase
         end
      end
   end

`ifdef CSR_COUNTERS_EN
   logic [63:0] w_cnt_wdata;
   logic        w_cyc_lo;
   logic        w_cyc_hi;
   logic        w_ret_lo;
   logic        w_ret_hi;

   always_comb begin
      w_cnt_wdata = {2{w_new[31:0]}};
      if (XLEN == 64) w_cnt_wdata[XLEN-1:0] = w_new;
   end

   assign w_cyc_lo = w_csr_we & (csr_addr == CSR_MCYCLE);
   assign w_ret_lo = w_csr_we & (csr_addr == CSR_MINSTRET);
   assign w_cyc_hi = (XLEN == 64) ? w_cyc_lo
                   : w_csr_we & (csr_addr == CSR_MCYCLEH);
   assign w_ret_hi = (XLEN == 64) ? w_ret_lo
                   : w_csr_we & (csr_addr == CSR_MINSTRETH);

   ysyx_23060236_csr_counter u_mcycle (
      .clock   (clock),
      .reset   (reset),
      .i_inc   (1'b1),
      .i_wr_lo (w_cyc_lo),
      .i_wr_hi (w_cyc_hi),
      .i_wdata (w_cnt_wdata),
      .o_cnt   (w_mcycle)
   );

   ysyx_23060236_csr_counter u_minstret (
      .clock   (clock),
      .reset   (reset),
      .i_inc   (valid & ~w_trap),
      .i_wr_lo (w_ret_lo),
      .i_wr_hi (w_ret_hi),
      .i_wdata (w_cnt_wdata),
      .o_cnt   (w_minstret)
   );
`else
   assign w_mcycle   = '0;
   assign w_minstret = '0;
`endif

endmodule

// File: doc/ysyx_23060236_csr_trap_unit.md
Name: ysyx_23060236_csr_trap_unit

Overview:
- Parametrised machine-mode CSR file and trap controller for the NPC core.
- Executes Zicsr read/write/set/clear operations.
- Handles synchronous traps (ecall, ebreak) and the machine timer interrupt, and implements mret with full MIE/MPIE stacking.
- Sits beside the EXU: computes trap and return targets, and keeps cycle and instruction-retired counters.

Parameters:
- XLEN, 32, register width; legal values are 32 and 64.
- MVENDORID, 32'h79737978, value read from mvendorid.
- MARCHID, 32'h015fdf0c, value read from marchid.
- MTVEC_VEC, 1, 1 = mtvec MODE field is writable (vectored mode allowed); 0 = MODE is hardwired to 0.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- valid  in  1  instruction in EXU commits this cycle; all architectural updates are gated by it
- csr_addr  in  12  CSR address
- csr_op  in  2  00 none, 01 write, 10 set, 11 clear
- csr_wdata  in  XLEN  rs1 value or zimm
- csr_rdata  out  XLEN  current (pre-update) value of the addressed CSR
- csr_illegal  out  1  csr_op!=00 and the address is unimplemented, or the op writes a read-only CSR
- inst_ecall  in  1  ecall in EXU
- inst_ebreak  in  1  ebreak in EXU
- inst_mret  in  1  mret in EXU
- epc  in  XLEN  PC of the instruction in EXU
- timer_irq  in  1  level machine-timer interrupt from CLINT
- jump  out  XLEN  redirect target
- jump_en  out  1  redirect request
- trap_taken  out  1  a trap or interrupt is being entered this cycle

Behaviour:
- CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344 (read-only), mvendorid 0xF11 (RO), marchid 0xF12 (RO), mcycle 0xB00, minstret 0xB02; for XLEN=32 also mcycleh 0xB80 and minstreth 0xB82.
- Reset values:
  - mstatus = 0x1800 (MPP=11).
  - mie, mepc, mcause, mtvec, all counters and mtip_q = 0.
  - Outputs are combinational from this state, so jump_en=0 and trap_taken=0 while valid=0.
- Storage widths:
  - mstatus keeps only MIE(bit3), MPIE(bit7) and MPP(12:11, hardwired 11); all other bits read 0.
  - mie and mip implement only MTIE/MTIP (bit7).
  - mepc[1:0] reads 0.
- mtip_q registers timer_irq every cycle; this gives one cycle of latency. mip.MTIP = mtip_q.
- irq = mtip_q & mie.MTIE & mstatus.MIE.
- Priority when valid=1: irq > ecall/ebreak > mret > CSR op.
  - A trap suppresses that instruction's CSR write and its minstret increment.
- Trap entry, applied on the clock edge:
  - mepc <= epc.
  - mcause <= {1,0..0,7} for irq, 11 for ecall, 3 for ebreak.
  - MPIE <= MIE; MIE <= 0.
  - trap_taken = 1 during the entry cycle.
  - jump = mtvec.BASE, or BASE + 4*cause when MODE=1 and the trap is an interrupt.
- mret: jump = mepc; on the clock edge MIE <= MPIE and MPIE <= 1.
- jump_en = valid & (irq | ecall | ebreak | mret).
- CSR op: new = wdata (write), old|wdata (set), old&~wdata (clear).
  - Set or clear with wdata=0 performs no write and does not raise illegal.
  - An illegal op performs no write.
- Counters:
  - mcycle is 64-bit, +1 every cycle.
  - minstret is 64-bit, +1 on valid when no trap is taken.
  - Both wrap from 2^64-1 to 0.
  - A CSR write to any counter half takes precedence over the increment that cycle; the other half is left unchanged.
- Reset asserted mid-operation aborts any pending redirect; registered state returns to the reset values on the next edge.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
  - Defined: mcycle/minstret (and their high halves) are implemented as specified above.
  - Undefined: those addresses read 0, writes to them are ignored, they do not raise illegal, and no counter flops are synthesised.

Decomposition:
- Shared package ysyx_23060236_csr_pkg holds:
  - CSR address constants.
  - csr_op encodings.
  - mcause codes.
  - mstatus bit positions.
- One natural sub-module: ysyx_23060236_csr_counter, a 64-bit counter with increment enable and a per-half write port, instantiated twice.

Test Plan:
- Reset, then read mstatus -> csr_rdata=0x1800; read mvendorid -> 0x79737978.
- csrrw mtvec=0x80000100, then ecall at epc=0x80000040 -> jump=0x80000100, jump_en=1; afterwards mepc=0x80000040 and mcause=11.
- Set mstatus.MIE and mie.MTIE, mtvec=0x80000101, raise timer_irq -> two cycles later jump=0x8000011C, mcause=0x80000007, MIE=0, MPIE=1.
- Follow the interrupt with mret -> jump=mepc, MIE=1, MPIE=1.
- Timer irq and ecall in the same valid cycle -> interrupt taken, mcause=0x80000007, ecall CSR effects absent.
- Write mcycle=0xFFFFFFFF (XLEN=32), then idle 2 cycles -> mcycleh=1 and mcycle=1. Write mip -> csr_illegal=1 and mip unchanged.
